sbr_drain: RTL and testbench
============================

SBR_DRAIN -- requirements
Module: sbr_drain

Interface
REQ-001 Parameter MAX_ENTRIES, default `MAX_SBR_ENTRIES; number of SBR table entries, used only for address range checks.
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 start  in  1  one-cycle request to drain the highest-demand SBR; sampled only in IDLE.
REQ-005 abort  in  1  terminate the drain from any state.
REQ-006 busy  out  1  high in every state except IDLE.
REQ-007 done  out  1  one-cycle pulse when a drain ends (normal, empty or error).
REQ-008 empty  out  1  valid with done; high when no SBR had requests.
REQ-009 err  out  1  valid with done; high when the SRR chain length disagreed with row_count.
REQ-010 find_max_en  out  1  drives the SBR table max search.
REQ-011 max_addr / max_requests  in  `SBR_ID_WIDTH / `REQUEST_ID_WIDTH  combinational max-search result.
REQ-012 sbr_rd_addr  out  `SBR_ID_WIDTH  SBR table read address; 1-cycle registered read latency.
REQ-013 sbr_rd_bank_group, sbr_rd_bank, sbr_rd_row_count, sbr_rd_head_srr, sbr_rd_tail_srr  in  table widths  SBR read data.
REQ-014 srr_rd_addr  out  `SRR_ID_WIDTH  SRR table read address; 1-cycle registered read latency.
REQ-015 srr_rd_row, srr_rd_req_count, srr_rd_next  in  `ROW_WIDTH / `REQUEST_ID_WIDTH / `SRR_ID_WIDTH  SRR entry data.
REQ-016 cmd_valid / cmd_ready  out / in  1 / 1  command handshake.
REQ-017 cmd_bank_group, cmd_bank, cmd_row, cmd_req_count, cmd_srr_id, cmd_last  out  matching widths  command payload; cmd_last marks the final row of the SBR.
REQ-018 sbr_clear  out  1  one-cycle pulse with done when the drain ended normally and err is low.

Function
REQ-019 FSM states IDLE, FIND, SBR_WAIT, SRR_REQ, SRR_WAIT, ISSUE, NEXT, FINISH.
REQ-020 IDLE->FIND on start; FIND asserts find_max_en for exactly one cycle and registers max_addr/max_requests.
REQ-021 FIND: max_requests==0 -> FINISH with empty=1; else drive sbr_rd_addr=max_addr and go SBR_WAIT.
REQ-022 SBR_WAIT (1 cycle) captures bank_group, bank, row_count, head, tail; row_count==0 -> FINISH with empty=1; else cur_srr=head, rows_issued=0, -> SRR_REQ.
REQ-023 SRR_REQ drives srr_rd_addr=cur_srr; SRR_WAIT captures row, req_count, next; -> ISSUE.
REQ-024 ISSUE holds cmd_valid high with payload stable until cmd_ready; transfer on cmd_valid&&cmd_ready, then -> NEXT.
REQ-025 cmd_last=1 when cur_srr==tail or rows_issued+1==row_count.
REQ-026 NEXT increments rows_issued (width `SRR_ID_WIDTH, no wrap beyond row_count); if cmd_last was set -> FINISH, else cur_srr=next -> SRR_REQ.
REQ-027 err=1 when the tail is reached with rows_issued+1!=row_count, or row_count reached with cur_srr!=tail.
REQ-028 FINISH: done=1 for one cycle, sbr_clear as REQ-018, -> IDLE; minimum drain latency start->done is 2 cycles (empty case).
REQ-029 start while busy is ignored; start coincident with abort in IDLE is ignored.
REQ-030 abort in any non-IDLE state -> IDLE next cycle, cmd_valid drops, done/sbr_clear not pulsed; abort during a cmd transfer cycle still counts that transfer as accepted by the consumer.
REQ-031 Outputs other than the handshake are registered; find_max_en, sbr_rd_addr, srr_rd_addr are decoded from state/registers.

Reset
REQ-032 On rst_n low, state=IDLE and busy, done, empty, err, find_max_en, cmd_valid, cmd_last, sbr_clear =0; all address, payload and counter registers =0.
REQ-033 Reset asserted mid-drain takes effect immediately, independent of clk.

Structure
REQ-034 `ROW_WIDTH and any new FSM state encodings are added to dram_scheduler_types.vh; existing SBR/SRR/REQUEST widths are reused from it.
REQ-035 Single flat module; no sub-module required.

Verification
REQ-036 Empty table: start with max_requests=0 -> done+empty at cycle 2, no cmd_valid, no sbr_clear.
REQ-037 SBR at addr 3, row_count=3, chain 5->9->2 (tail 2), cmd_ready=1 -> three commands srr_id 5,9,2 in order, cmd_last only on 2, done+sbr_clear, err=0.
REQ-038 Same chain with cmd_ready low 4 cycles on second command -> payload (srr 9) held stable, no duplicate, order preserved.
REQ-039 row_count=2 but tail reached after 1 row -> one command with cmd_last, done with err=1, sbr_clear=0.
REQ-040 abort asserted in SRR_WAIT of second row -> IDLE next cycle, no done, following start runs normally.
REQ-041 rst_n pulsed low during ISSUE -> cmd_valid and busy 0 immediately, all outputs at reset values.

Source files
------------

// File: rtl/sbr_drain_pkg.sv
// Shared widths, table sizing and FSM state encoding for the SBR drain engine.
package sbr_drain_pkg;

  localparam int unsigned MAX_SBR_ENTRIES  = 12;
  localparam int unsigned SBR_ID_WIDTH     = 4;
  localparam int unsigned SRR_ID_WIDTH     = 6;
  localparam int unsigned REQUEST_ID_WIDTH = 8;
  localparam int unsigned ROW_WIDTH        = 14;
  localparam int unsigned BANK_GROUP_WIDTH = 2;
  localparam int unsigned BANK_WIDTH       = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FIND,
    ST_SBR_WAIT,
    ST_SRR_REQ,
    ST_SRR_WAIT,
    ST_ISSUE,
    ST_NEXT,
    ST_FINISH
  } state_t;

endpackage

// File: rtl/sbr_drain.sv
// Drains the highest-demand SBR: finds it, walks its SRR chain and issues one
// command per row over a valid/ready handshake, then reports done/empty/err.
module sbr_drain
  import sbr_drain_pkg::*;
#(
  parameter int unsigned MAX_ENTRIES = MAX_SBR_ENTRIES
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        abort,
  output logic                        busy,
  output logic                        done,
  output logic                        empty,
  output logic                        err,
  output logic                        find_max_en,
  input  logic [SBR_ID_WIDTH-1:0]     max_addr,
  input  logic [REQUEST_ID_WIDTH-1:0] max_requests,
  output logic [SBR_ID_WIDTH-1:0]     sbr_rd_addr,
  input  logic [BANK_GROUP_WIDTH-1:0] sbr_rd_bank_group,
  input  logic [BANK_WIDTH-1:0]       sbr_rd_bank,
  input  logic [SRR_ID_WIDTH-1:0]     sbr_rd_row_count,
  input  logic [SRR_ID_WIDTH-1:0]     sbr_rd_head_srr,
  input  logic [SRR_ID_WIDTH-1:0]     sbr_rd_tail_srr,
  output logic [SRR_ID_WIDTH-1:0]     srr_rd_addr,
  input  logic [ROW_WIDTH-1:0]        srr_rd_row,
  input  logic [REQUEST_ID_WIDTH-1:0] srr_rd_req_count,
  input  logic [SRR_ID_WIDTH-1:0]     srr_rd_next,
  output logic                        cmd_valid,
  input  logic                        cmd_ready,
  output logic [BANK_GROUP_WIDTH-1:0] cmd_bank_group,
  output logic [BANK_WIDTH-1:0]       cmd_bank,
  output logic [ROW_WIDTH-1:0]        cmd_row,
  output logic [REQUEST_ID_WIDTH-1:0] cmd_req_count,
  output logic [SRR_ID_WIDTH-1:0]     cmd_srr_id,
  output logic                        cmd_last,
  output logic                        sbr_clear
);

  state_t                  state;
  logic [SBR_ID_WIDTH-1:0] sbr_addr_q;
  logic [SRR_ID_WIDTH-1:0] row_count_q;
  logic [SRR_ID_WIDTH-1:0] tail_q;
  logic [SRR_ID_WIDTH-1:0] cur_srr;
  logic [SRR_ID_WIDTH-1:0] next_q;
  logic [SRR_ID_WIDTH-1:0] rows_issued;
  logic [SRR_ID_WIDTH-1:0] rows_inc;
  logic                    err_pend;
  logic                    at_tail;
  logic                    at_count;

  // Table read addresses: the SBR address is presented straight from the max
  // search during FIND so the registered read lands in SBR_WAIT.
  assign find_max_en = (state == ST_FIND);
  assign sbr_rd_addr = (state == ST_FIND) ? max_addr : sbr_addr_q;
  assign srr_rd_addr = cur_srr;
  assign cmd_valid   = (state == ST_ISSUE);

  // Chain-end detection for the row currently being fetched.
  assign rows_inc = rows_issued + SRR_ID_WIDTH'(1);
  assign at_tail  = (cur_srr == tail_q);
  assign at_count = (rows_inc == row_count_q);

  // Drain sequencer with registered status and command payload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      busy           <= 1'b0;
      done           <= 1'b0;
      empty          <= 1'b0;
      err            <= 1'b0;
      sbr_clear      <= 1'b0;
      sbr_addr_q     <= '0;
      row_count_q    <= '0;
      tail_q         <= '0;
      cur_srr        <= '0;
      next_q         <= '0;
      rows_issued    <= '0;
      err_pend       <= 1'b0;
      cmd_bank_group <= '0;
      cmd_bank       <= '0;
      cmd_row        <= '0;
      cmd_req_count  <= '0;
      cmd_srr_id     <= '0;
      cmd_last       <= 1'b0;
    end else begin
      done      <= 1'b0;
      sbr_clear <= 1'b0;
      if (abort && (state != ST_IDLE)) begin
        state <= ST_IDLE;
        busy  <= 1'b0;
        empty <= 1'b0;
        err   <= 1'b0;
      end else begin
        unique case (state)
          ST_IDLE: begin
            if (start && !abort) begin
              state <= ST_FIND;
              busy  <= 1'b1;
            end
          end
          ST_FIND: begin
            if (max_requests == '0) begin
              state <= ST_FINISH;
              empty <= 1'b1;
              done  <= 1'b1;
            end else begin
              sbr_addr_q <= max_addr;
              state      <= ST_SBR_WAIT;
            end
          end
          ST_SBR_WAIT: begin
            cmd_bank_group <= sbr_rd_bank_group;
            cmd_bank       <= sbr_rd_bank;
            row_count_q    <= sbr_rd_row_count;
            tail_q         <= sbr_rd_tail_srr;
            cur_srr        <= sbr_rd_head_srr;
            rows_issued    <= '0;
            if (sbr_rd_row_count == '0) begin
              state <= ST_FINISH;
              empty <= 1'b1;
              done  <= 1'b1;
            end else begin
              state <= ST_SRR_REQ;
            end
          end
          ST_SRR_REQ: begin
            state <= ST_SRR_WAIT;
          end
          ST_SRR_WAIT: begin
            cmd_row       <= srr_rd_row;
            cmd_req_count <= srr_rd_req_count;
            cmd_srr_id    <= cur_srr;
            next_q        <= srr_rd_next;
            // Either end condition terminates; disagreement between them is an error.
            cmd_last      <= at_tail || at_count;
            err_pend      <= at_tail != at_count;
            state         <= ST_ISSUE;
          end
          ST_ISSUE: begin
            if (cmd_ready) begin
              state <= ST_NEXT;
            end
          end
          ST_NEXT: begin
            rows_issued <= rows_inc;
            if (cmd_last) begin
              state     <= ST_FINISH;
              done      <= 1'b1;
              err       <= err_pend;
              sbr_clear <= !err_pend;
            end else begin
              cur_srr <= next_q;
              state   <= ST_SRR_REQ;
            end
          end
          ST_FINISH: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            empty <= 1'b0;
            err   <= 1'b0;
          end
        endcase
      end
    end
  end

  // The max search must only ever nominate an existing table entry.
  a_max_addr_range: assert property (@(posedge clk) disable iff (!rst_n)
    ((state == ST_FIND) && (max_requests != '0)) |-> (32'(max_addr) < MAX_ENTRIES));

endmodule

// File: tb/tb_sbr_drain.sv
// Directed bench for sbr_drain with behavioural SBR/SRR tables.
module tb_sbr_drain;
  import sbr_drain_pkg::*;

  logic                        clk = 1'b0;
  logic                        rst_n = 1'b0;
  logic                        start = 1'b0;
  logic                        abort = 1'b0;
  logic                        cmd_ready = 1'b1;
  logic [SBR_ID_WIDTH-1:0]     max_addr = '0;
  logic [REQUEST_ID_WIDTH-1:0] max_requests = '0;
  logic                        busy, done, empty, err, find_max_en, cmd_valid, cmd_last, sbr_clear;
  logic [SBR_ID_WIDTH-1:0]     sbr_rd_addr;
  logic [SRR_ID_WIDTH-1:0]     srr_rd_addr;
  logic [BANK_GROUP_WIDTH-1:0] sbr_rd_bank_group = '0, cmd_bank_group;
  logic [BANK_WIDTH-1:0]       sbr_rd_bank = '0, cmd_bank;
  logic [SRR_ID_WIDTH-1:0]     sbr_rd_row_count = '0, sbr_rd_head_srr = '0, sbr_rd_tail_srr = '0;
  logic [ROW_WIDTH-1:0]        srr_rd_row = '0, cmd_row;
  logic [REQUEST_ID_WIDTH-1:0] srr_rd_req_count = '0, cmd_req_count;
  logic [SRR_ID_WIDTH-1:0]     srr_rd_next = '0, cmd_srr_id;

  logic [BANK_GROUP_WIDTH-1:0] sbr_bg_tab   [16];
  logic [BANK_WIDTH-1:0]       sbr_bank_tab [16];
  logic [SRR_ID_WIDTH-1:0]     sbr_rc_tab   [16];
  logic [SRR_ID_WIDTH-1:0]     sbr_head_tab [16];
  logic [SRR_ID_WIDTH-1:0]     sbr_tail_tab [16];
  logic [ROW_WIDTH-1:0]        srr_row_tab  [64];
  logic [REQUEST_ID_WIDTH-1:0] srr_req_tab  [64];
  logic [SRR_ID_WIDTH-1:0]     srr_next_tab [64];

  int checks = 0;
  int passed = 0;

  typedef struct {
    logic [SBR_ID_WIDTH-1:0]     addr;
    logic [REQUEST_ID_WIDTH-1:0] req;
    int                          stall_idx;
    int                          stall_len;
    int                          ncmd;
    logic [2:0][SRR_ID_WIDTH-1:0] ids;
    logic                        empty;
    logic                        err;
    logic                        clear;
    logic [BANK_GROUP_WIDTH-1:0] bg;
    logic [BANK_WIDTH-1:0]       bank;
    int                          lat;
  } vec_t;

  localparam int NV = 7;
  vec_t vecs [NV];

  sbr_drain #(.MAX_ENTRIES(MAX_SBR_ENTRIES)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .busy(busy), .done(done),
    .empty(empty), .err(err), .find_max_en(find_max_en), .max_addr(max_addr),
    .max_requests(max_requests), .sbr_rd_addr(sbr_rd_addr), .sbr_rd_bank_group(sbr_rd_bank_group),
    .sbr_rd_bank(sbr_rd_bank), .sbr_rd_row_count(sbr_rd_row_count), .sbr_rd_head_srr(sbr_rd_head_srr),
    .sbr_rd_tail_srr(sbr_rd_tail_srr), .srr_rd_addr(srr_rd_addr), .srr_rd_row(srr_rd_row),
    .srr_rd_req_count(srr_rd_req_count), .srr_rd_next(srr_rd_next), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .cmd_bank_group(cmd_bank_group), .cmd_bank(cmd_bank), .cmd_row(cmd_row),
    .cmd_req_count(cmd_req_count), .cmd_srr_id(cmd_srr_id), .cmd_last(cmd_last), .sbr_clear(sbr_clear)
  );

  always #5 clk = ~clk;

  // Registered table reads, one cycle of latency.
  always @(posedge clk) begin
    sbr_rd_bank_group <= sbr_bg_tab[sbr_rd_addr];
    sbr_rd_bank       <= sbr_bank_tab[sbr_rd_addr];
    sbr_rd_row_count  <= sbr_rc_tab[sbr_rd_addr];
    sbr_rd_head_srr   <= sbr_head_tab[sbr_rd_addr];
    sbr_rd_tail_srr   <= sbr_tail_tab[sbr_rd_addr];
    srr_rd_row        <= srr_row_tab[srr_rd_addr];
    srr_rd_req_count  <= srr_req_tab[srr_rd_addr];
    srr_rd_next       <= srr_next_tab[srr_rd_addr];
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", name, got, exp);
    else passed++;
  endtask

  task automatic set_sbr(input int a, input int bg, input int bk, input int rc, input int hd, input int tl);
    sbr_bg_tab[a]   = BANK_GROUP_WIDTH'(bg);
    sbr_bank_tab[a] = BANK_WIDTH'(bk);
    sbr_rc_tab[a]   = SRR_ID_WIDTH'(rc);
    sbr_head_tab[a] = SRR_ID_WIDTH'(hd);
    sbr_tail_tab[a] = SRR_ID_WIDTH'(tl);
  endtask

  task automatic set_srr(input int a, input int row, input int rq, input int nx);
    srr_row_tab[a]  = ROW_WIDTH'(row);
    srr_req_tab[a]  = REQUEST_ID_WIDTH'(rq);
    srr_next_tab[a] = SRR_ID_WIDTH'(nx);
  endtask

  // Entered and left on a falling edge.
  task automatic run_vec(input int idx, input vec_t v);
    int n = 0, fme = 0, stall_cnt = 0, hold_err = 0, clr_cnt = 0, done_cyc = 0;
    logic done_seen = 1'b0, emp = 1'b0, er = 1'b0;
    logic [SRR_ID_WIDTH-1:0] held = '0;
    string tag;
    tag = $sformatf("v%0d", idx);
    max_addr = v.addr;
    max_requests = v.req;
    start = 1'b1;
    for (int cyc = 1; cyc <= 80 && !done_seen; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (find_max_en) fme++;
      if (sbr_clear) clr_cnt++;
      if (cmd_valid && n == v.stall_idx && stall_cnt < v.stall_len) begin
        cmd_ready = 1'b0;
        start = 1'b1;
        if (stall_cnt == 0) held = cmd_srr_id;
        else if (cmd_srr_id != held) hold_err++;
        stall_cnt++;
      end else begin
        cmd_ready = 1'b1;
      end
      if (cmd_valid && cmd_ready) begin
        if (n < 3) chk({tag, "_srr_id"}, cmd_srr_id, v.ids[n]);
        chk({tag, "_row"}, cmd_row, srr_row_tab[cmd_srr_id]);
        chk({tag, "_req_count"}, cmd_req_count, srr_req_tab[cmd_srr_id]);
        chk({tag, "_bank_group"}, cmd_bank_group, v.bg);
        chk({tag, "_bank"}, cmd_bank, v.bank);
        chk({tag, "_cmd_last"}, cmd_last, 32'(n == v.ncmd - 1));
        n++;
      end
      if (done) begin
        done_seen = 1'b1;
        emp = empty;
        er = err;
        done_cyc = cyc;
      end
    end
    start = 1'b0;
    cmd_ready = 1'b1;
    chk({tag, "_done_seen"}, done_seen, 1);
    chk({tag, "_ncmd"}, n, v.ncmd);
    chk({tag, "_empty"}, emp, v.empty);
    chk({tag, "_err"}, er, v.err);
    chk({tag, "_sbr_clear"}, clr_cnt, v.clear);
    chk({tag, "_find_max_en_cycles"}, fme, 1);
    if (v.lat != 0) chk({tag, "_latency"}, done_cyc, v.lat);
    if (v.stall_len != 0) begin
      chk({tag, "_stall_cycles"}, stall_cnt, v.stall_len);
      chk({tag, "_stall_hold"}, hold_err, 0);
      chk({tag, "_stall_srr"}, held, v.ids[v.stall_idx]);
    end
    @(negedge clk);
    chk({tag, "_done_pulse"}, done, 0);
    chk({tag, "_idle_busy"}, busy, 0);
  endtask

  initial begin
    int seen;
    for (int i = 0; i < 16; i++) set_sbr(i, 0, 0, 0, 0, 0);
    for (int i = 0; i < 64; i++) set_srr(i, 0, 0, 0);
    set_sbr(3, 2, 1, 3, 5, 2);
    set_sbr(7, 1, 3, 2, 5, 5);
    set_sbr(1, 1, 1, 0, 0, 0);
    set_sbr(4, 3, 0, 2, 9, 11);
    set_sbr(6, 0, 2, 1, 11, 11);
    set_srr(5, 'h0105, 3, 9);
    set_srr(9, 'h0209, 1, 2);
    set_srr(2, 'h0302, 4, 11);
    set_srr(11, 'h040B, 2, 5);

    //         addr   req  stall  n  ids (last..first)        emp   err   clr   bg    bank  lat
    vecs[0] = '{4'd0, 8'd0, -1, 0, 0, {6'd0, 6'd0, 6'd0},   1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 2};
    vecs[1] = '{4'd3, 8'd5, -1, 0, 3, {6'd2, 6'd9, 6'd5},   1'b0, 1'b0, 1'b1, 2'd2, 2'd1, 0};
    vecs[2] = '{4'd3, 8'd5, 1,  4, 3, {6'd2, 6'd9, 6'd5},   1'b0, 1'b0, 1'b1, 2'd2, 2'd1, 0};
    vecs[3] = '{4'd7, 8'd2, -1, 0, 1, {6'd0, 6'd0, 6'd5},   1'b0, 1'b1, 1'b0, 2'd1, 2'd3, 0};
    vecs[4] = '{4'd1, 8'd1, -1, 0, 0, {6'd0, 6'd0, 6'd0},   1'b1, 1'b0, 1'b0, 2'd1, 2'd1, 3};
    vecs[5] = '{4'd4, 8'd3, -1, 0, 2, {6'd0, 6'd2, 6'd9},   1'b0, 1'b1, 1'b0, 2'd3, 2'd0, 0};
    vecs[6] = '{4'd6, 8'd1, -1, 0, 1, {6'd0, 6'd0, 6'd11},  1'b0, 1'b0, 1'b1, 2'd0, 2'd2, 0};

    #1;
    chk("reset_status", {busy, done, empty, err, find_max_en, cmd_valid, cmd_last, sbr_clear}, 0);
    chk("reset_addrs", {sbr_rd_addr, srr_rd_addr}, 0);
    chk("reset_payload", {cmd_bank_group, cmd_bank, cmd_row, cmd_req_count, cmd_srr_id}, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < NV; i++) run_vec(i, vecs[i]);

    // start together with abort while idle must not launch a drain
    max_addr = 4'd3; max_requests = 8'd5;
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("start_abort_idle_busy", busy, 0);
    chk("start_abort_idle_find", find_max_en, 0);

    // abort in SRR_WAIT of the second row
    start = 1'b1;
    seen = 0;
    for (int c = 0; c < 40 && seen == 0; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (srr_rd_addr == 6'd9 && !cmd_valid) seen = 1;
    end
    chk("abort_reach_row2", seen, 1);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_cmd_valid", cmd_valid, 0);
    chk("abort_done", done, 0);
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (done || sbr_clear || cmd_valid || busy) seen++;
    end
    chk("abort_quiet", seen, 0);
    run_vec(10, vecs[6]);

    // asynchronous reset while a command is waiting in ISSUE
    max_addr = 4'd7; max_requests = 8'd2;
    start = 1'b1;
    seen = 0;
    for (int c = 0; c < 20 && seen == 0; c++) begin
      @(negedge clk);
      start = 1'b0;
      cmd_ready = 1'b0;
      if (cmd_valid) seen = 1;
    end
    chk("rst_reach_issue", seen, 1);
    chk("rst_pre_last", cmd_last, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_status", {busy, done, empty, err, find_max_en, cmd_valid, cmd_last, sbr_clear}, 0);
    chk("rst_async_addrs", {sbr_rd_addr, srr_rd_addr}, 0);
    chk("rst_async_payload", {cmd_bank_group, cmd_bank, cmd_row, cmd_req_count, cmd_srr_id}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cmd_ready = 1'b1;
    @(negedge clk);
    run_vec(11, vecs[1]);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
